// File: rtl/conv3x3_engine_pkg.sv
// Shared types and constants for the 3x3 convolution engine.
//   state_t     : control FSM encoding
//   MAC_LATENCY : cycles from window-valid to out_valid
//   NUM_TAPS    : weights per kernel, index k = 3*r + c
package conv3x3_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int         MAC_LATENCY = 4;
  localparam int         NUM_TAPS    = 9;
  localparam int         NUM_ROWS    = 3;
  localparam logic [3:0] LAST_TAP    = 4'd8;

  // Row 0 is the oldest window row (win2); column 0 sits in the pixel MSBs.
  function automatic int tap_idx(int r, int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/conv3x3_engine_if.sv
// Line-buffer FIFO read port as seen by the convolution engine.
//   win2/win1/win0 : three window rows, three pixels each (column 0 in MSBs)
//   fifo_cnt       : FIFO occupancy
//   fifo_empty     : FIFO empty flag
//   fifo_ren       : read strobe from the engine
// master = engine side, slave = FIFO side.
interface conv3x3_engine_if #(
  parameter int WIDTH    = 8,
  parameter int ADDR_BIT = 5
);
  logic [3*WIDTH-1:0] win2;
  logic [3*WIDTH-1:0] win1;
  logic [3*WIDTH-1:0] win0;
  logic [ADDR_BIT:0]  fifo_cnt;
  logic               fifo_empty;
  logic               fifo_ren;

  modport master (
    output fifo_ren,
    input  win2, win1, win0, fifo_cnt, fifo_empty
  );

  modport slave (
    input  fifo_ren,
    output win2, win1, win0, fifo_cnt, fifo_empty
  );
endinterface

// File: rtl/conv3x3_engine_mac.sv
// Four-stage signed MAC datapath for one 3x3 window per cycle.
//   stage 1: nine pixel*weight products
//   stage 2: per-row sums
//   stage 3: bias + row sums
//   stage 4: ReLU, arithmetic shift, saturate to OUT_WIDTH
// Ports: clk, rst, win_vld + win2/1/0 (window), wgt (packed taps), bias,
//        out_data/out_valid (result), pipe_busy (any window still in flight
//        ahead of the output register).
module conv3x3_engine_mac
  import conv3x3_engine_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int WGT_WIDTH = 8,
  parameter int ACC_WIDTH = 20,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                win_vld,
  input  logic [3*WIDTH-1:0]                  win2,
  input  logic [3*WIDTH-1:0]                  win1,
  input  logic [3*WIDTH-1:0]                  win0,
  input  logic [NUM_TAPS-1:0][WGT_WIDTH-1:0]  wgt,
  input  logic signed [ACC_WIDTH-1:0]         bias,
  output logic [OUT_WIDTH-1:0]                out_data,
  output logic                                out_valid,
  output logic                                pipe_busy
);

  localparam int PW = WIDTH + WGT_WIDTH + 1;
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  logic [NUM_TAPS-1:0][WIDTH-1:0] pix;
  logic signed [PW-1:0]        prod_d [NUM_TAPS];
  logic signed [PW-1:0]        prod_q [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0] row_d  [NUM_ROWS];
  logic signed [ACC_WIDTH-1:0] row_q  [NUM_ROWS];
  logic signed [ACC_WIDTH-1:0] sum_d;
  logic signed [ACC_WIDTH-1:0] sum_q;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic [OUT_WIDTH-1:0]        res_d;
  // vld[0]: products, vld[1]: row sums, vld[2]: biased sum
  logic [MAC_LATENCY-2:0]      vld;

  always_comb begin
    pix = '0;
    for (int c = 0; c < 3; c++) begin
      pix[tap_idx(0, c)] = win2[(2-c)*WIDTH +: WIDTH];
      pix[tap_idx(1, c)] = win1[(2-c)*WIDTH +: WIDTH];
      pix[tap_idx(2, c)] = win0[(2-c)*WIDTH +: WIDTH];
    end
  end

  // Pixels are unsigned: a zero MSB makes them safe signed operands.
  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      prod_d[k] = PW'($signed({1'b0, pix[k]})) * PW'($signed(wgt[k]));
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      row_d[r] = ACC_WIDTH'(prod_q[tap_idx(r, 0)])
               + ACC_WIDTH'(prod_q[tap_idx(r, 1)])
               + ACC_WIDTH'(prod_q[tap_idx(r, 2)]);
    end
  end

  assign sum_d = bias + row_q[0] + row_q[1] + row_q[2];

  always_comb begin
    shifted = sum_q >>> SHIFT;
    res_d   = shifted[OUT_WIDTH-1:0];
    if (sum_q[ACC_WIDTH-1]) begin
      res_d = '0;
    end else if (shifted > OUT_MAX) begin
      res_d = '1;
    end
  end

  // Data registers only load with a valid token so out_data holds between results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sum_q     <= '0;
      for (int k = 0; k < NUM_TAPS; k++) prod_q[k] <= '0;
      for (int r = 0; r < NUM_ROWS; r++) row_q[r] <= '0;
    end else begin
      vld       <= {vld[MAC_LATENCY-3:0], win_vld};
      out_valid <= vld[MAC_LATENCY-2];
      if (win_vld) prod_q   <= prod_d;
      if (vld[0])  row_q    <= row_d;
      if (vld[1])  sum_q    <= sum_d;
      if (vld[2])  out_data <= res_d;
    end
  end

  assign pipe_busy = win_vld | (|vld);

endmodule

// File: rtl/conv3x3_engine.sv
// 3x3 convolution engine: reads windows from the line-buffer FIFO, drops
// row-wrap windows and streams results from a pipelined MAC.
//   clk, rst              : clock, async active-high reset
//   start, row_len, n_rows: map control (start honoured in IDLE only)
//   w_wen, w_addr, w_data : weight writes, ignored while busy
//   bias                  : signed bias
//   fifo                  : FIFO read port (master side)
//   out_data, out_valid   : result stream, no back-pressure
//   busy, done            : busy in RUN/FLUSH, done pulses one cycle at end
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing FIFO reads until every window of the map is read
// FLUSH | reads finished, draining the MAC pipeline
// DONE  | one-cycle done pulse
module conv3x3_engine
  import conv3x3_engine_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ADDR_BIT  = 5,
  parameter int WGT_WIDTH = 8,
  parameter int ACC_WIDTH = 20,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BIT-1:0]  row_len,
  input  logic [ADDR_BIT-1:0]  n_rows,
  input  logic                 w_wen,
  input  logic [3:0]           w_addr,
  input  logic [WGT_WIDTH-1:0] w_data,
  input  logic [ACC_WIDTH-1:0] bias,
  conv3x3_engine_if.master     fifo,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = 2 * ADDR_BIT;

  state_t                            state, state_nx;
  logic [ADDR_BIT-1:0]               col;
  logic [CW-1:0]                     rd_cnt;
  logic [CW-1:0]                     total;
  logic [ADDR_BIT+1:0]               need;
  logic                              dims_ok, col_ok, full_ok, ren, last_rd;
  logic                              win_vld, pipe_busy;
  logic [NUM_TAPS-1:0][WGT_WIDTH-1:0] wgt;

  assign dims_ok = (row_len >= ADDR_BIT'(3)) && (n_rows >= ADDR_BIT'(3));
  assign total   = CW'(n_rows - ADDR_BIT'(2)) * CW'(row_len) - CW'(2);
  assign last_rd = (rd_cnt == total - CW'(1));

  // A kept window needs two full rows plus three pixels behind it; the compare
  // runs one bit wider than fifo_cnt so 2*row_len+3 cannot overflow.
  assign need    = {1'b0, row_len, 1'b0} + (ADDR_BIT+2)'(3);
  assign full_ok = ({1'b0, fifo.fifo_cnt} >= need);
  assign col_ok  = (col <= row_len - ADDR_BIT'(3));

  // Wrap windows are discarded, so they only need something to pop.
  assign ren = (state == ST_RUN) && !fifo.fifo_empty && (col_ok ? full_ok : 1'b1);
  assign fifo.fifo_ren = ren;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = dims_ok ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (ren && last_rd) state_nx = ST_FLUSH;
      end
      ST_FLUSH: begin
        busy = 1'b1;
        if (!pipe_busy) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col     <= '0;
      rd_cnt  <= '0;
      win_vld <= 1'b0;
    end else begin
      // FIFO registers the window one cycle after ren, aligned with win_vld.
      win_vld <= ren & col_ok;
      if (state == ST_IDLE && start) begin
        col    <= '0;
        rd_cnt <= '0;
      end else if (ren) begin
        col    <= (col == row_len - ADDR_BIT'(1)) ? '0 : col + ADDR_BIT'(1);
        rd_cnt <= rd_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wgt <= '0;
    end else if (w_wen && !busy && (w_addr <= LAST_TAP)) begin
      wgt[w_addr] <= w_data;
    end
  end

  conv3x3_engine_mac #(
    .WIDTH     (WIDTH),
    .WGT_WIDTH (WGT_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT     (SHIFT)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .win_vld   (win_vld),
    .win2      (fifo.win2),
    .win1      (fifo.win1),
    .win0      (fifo.win0),
    .wgt       (wgt),
    .bias      (bias),
    .out_data  (out_data),
    .out_valid (out_valid),
    .pipe_busy (pipe_busy)
  );

endmodule

// File: tb/tb_conv3x3_engine.sv
// Bench for conv3x3_engine: a FIFO model feeds two engines (SHIFT=0 and
// SHIFT=4) in lockstep; results are compared against a direct 3x3
// convolution of the image array, including the 5-cycle ren-to-output latency.
module tb_conv3x3_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  row_len, n_rows;
  logic        w_wen;
  logic [3:0]  w_addr;
  logic [7:0]  w_data;
  logic [19:0] bias;
  logic [7:0]  out_a, out_b;
  logic        ov_a, ov_b, busy_a, busy_b, done_a, done_b;

  conv3x3_engine_if #(.WIDTH(8), .ADDR_BIT(5)) fa ();
  conv3x3_engine_if #(.WIDTH(8), .ADDR_BIT(5)) fb ();

  always #5 clk = ~clk;

  conv3x3_engine #(.WIDTH(8), .ADDR_BIT(5), .WGT_WIDTH(8), .ACC_WIDTH(20),
                   .OUT_WIDTH(8), .SHIFT(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .row_len(row_len), .n_rows(n_rows),
    .w_wen(w_wen), .w_addr(w_addr), .w_data(w_data), .bias(bias),
    .fifo(fa.master), .out_data(out_a), .out_valid(ov_a), .busy(busy_a), .done(done_a));

  conv3x3_engine #(.WIDTH(8), .ADDR_BIT(5), .WGT_WIDTH(8), .ACC_WIDTH(20),
                   .OUT_WIDTH(8), .SHIFT(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .row_len(row_len), .n_rows(n_rows),
    .w_wen(w_wen), .w_addr(w_addr), .w_data(w_data), .bias(bias),
    .fifo(fb.master), .out_data(out_b), .out_valid(ov_b), .busy(busy_b), .done(done_b));

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask

  // ---------------- reference data ----------------
  int img [256];
  int img_len = 0;
  int cur_L = 3;
  int wm [9];
  int bias_m;
  int exp_a_q [$];
  int exp_b_q [$];
  int exp_cyc_q [$];
  int exp_total, exp_reads;
  int out_cnt, last_out_cyc, done_cyc;

  function automatic int px(int i);
    return (i < img_len) ? img[i] : 0;
  endfunction

  function automatic logic [23:0] row_at(int idx);
    logic [23:0] v;
    for (int c = 0; c < 3; c++) v[(2-c)*8 +: 8] = 8'(px(idx + c));
    return v;
  endfunction

  function automatic int post(int s, int sh);
    int t;
    if (s < 0) return 0;
    t = s >>> sh;
    return (t > 255) ? 255 : t;
  endfunction

  // ---------------- FIFO model ----------------
  // Entry i of the stream presents the window whose top-left pixel is i.
  int cyc = 0;
  int wr = 0, rd = 0, ren_cnt = 0;
  bit wr_en = 0, fifo_clr = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_clr) begin
      wr <= 0; rd <= 0; ren_cnt <= 0;
    end else begin
      if (fa.fifo_ren) begin
        fa.win2 <= row_at(rd);
        fa.win1 <= row_at(rd + cur_L);
        fa.win0 <= row_at(rd + 2 * cur_L);
        rd      <= rd + 1;
        ren_cnt <= ren_cnt + 1;
        if ((rd % cur_L) <= cur_L - 3) exp_cyc_q.push_back(cyc + 5);
      end
      if (wr_en && wr < img_len && (wr - rd) < 32) wr <= wr + 1;
    end
  end

  assign fa.fifo_cnt   = 6'(wr - rd);
  assign fa.fifo_empty = (wr == rd);
  assign fb.win2       = fa.win2;
  assign fb.win1       = fa.win1;
  assign fb.win0       = fa.win0;
  assign fb.fifo_cnt   = fa.fifo_cnt;
  assign fb.fifo_empty = fa.fifo_empty;

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (fb.fifo_ren !== fa.fifo_ren) chk("ren_b", fb.fifo_ren, fa.fifo_ren);
      if (ov_b !== ov_a) chk("ov_b", ov_b, ov_a);
      if (done_b !== done_a) chk("done_b", done_b, done_a);
      if (ov_a) begin
        out_cnt++;
        last_out_cyc = cyc;
        if (exp_a_q.size() == 0) begin
          chk("out_over", out_cnt, exp_total);
        end else begin
          chk("out_a", out_a, exp_a_q.pop_front());
          chk("out_b", out_b, exp_b_q.pop_front());
          if (exp_cyc_q.size() == 0) chk("lat_q", exp_cyc_q.size(), 1);
          else chk("latency", cyc, exp_cyc_q.pop_front());
        end
      end
      if (done_a) done_cyc = cyc;
    end
  end

  // ---------------- tasks ----------------
  task automatic put_wgts();
    for (int k = 0; k < 16; k++) begin
      w_wen  = 1'b1;
      w_addr = 4'(k);
      w_data = (k < 9) ? 8'(wm[k]) : 8'($urandom);
      @(posedge clk); #1;
    end
    w_wen = 1'b0;
  endtask

  // mode 0: ramp 0,1,2..  mode 1: all 255  mode 2: random
  task automatic prep(int L, int n, int b, int mode);
    int s;
    cur_L = L; img_len = L * n;
    row_len = 5'(L); n_rows = 5'(n);
    bias_m = b; bias = 20'(b);
    for (int i = 0; i < img_len; i++)
      img[i] = (mode == 0) ? i : (mode == 1) ? 255 : int'($urandom_range(0, 255));
    exp_a_q.delete(); exp_b_q.delete(); exp_cyc_q.delete();
    exp_total = 0; out_cnt = 0; last_out_cyc = -1; done_cyc = -1;
    exp_reads = (L >= 3 && n >= 3) ? (n - 2) * L - 2 : 0;
    if (L >= 3 && n >= 3) begin
      for (int r0 = 0; r0 <= n - 3; r0++)
        for (int c0 = 0; c0 <= L - 3; c0++) begin
          s = bias_m;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              s += wm[3*r + c] * img[(r0 + r) * L + c0 + c];
          exp_a_q.push_back(post(s, 0));
          exp_b_q.push_back(post(s, 4));
          exp_total++;
        end
    end
    fifo_clr = 1; @(posedge clk); #1; fifo_clr = 0;
  endtask

  task automatic kick();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic finish_map(int pct);
    bit seen = 0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      if (done_a) seen = 1;
      else begin
        wr_en = ($urandom_range(0, 99) < pct);
        if (busy_a) begin
          // writes and starts while busy must be ignored
          w_wen  = 1'($urandom_range(0, 1));
          w_addr = 4'($urandom_range(0, 15));
          w_data = 8'($urandom);
          start  = 1'($urandom_range(0, 1));
        end else begin
          w_wen = 1'b0; start = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    w_wen = 1'b0; start = 1'b0; wr_en = 0;
    chk("done_seen", seen, 1);
    @(posedge clk); #1;
    chk("done_pulse", done_a, 0);
    chk("idle_busy", busy_a, 0);
    repeat (2) @(posedge clk); #1;
    chk("n_out", out_cnt, exp_total);
    chk("n_ren", ren_cnt, exp_reads);
    chk("left_over", exp_a_q.size(), 0);
    if (exp_total > 0) chk("done_lat", done_cyc, last_out_cyc + 1);
  endtask

  task automatic run_map(int L, int n, int b, int mode, int pct);
    prep(L, n, b, mode);
    kick();
    finish_map(pct);
  endtask

  task automatic set_all_w(int v);
    for (int k = 0; k < 9; k++) wm[k] = v;
    put_wgts();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; row_len = '0; n_rows = '0;
    w_wen = 1'b0; w_addr = '0; w_data = '0; bias = '0;
    for (int k = 0; k < 9; k++) wm[k] = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_out", out_a, 0);
    chk("rst_ov", ov_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_ren", fa.fifo_ren, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ramp image, unit weights: 54,63,72,99,108,117
    set_all_w(1);
    run_map(5, 4, 0, 0, 100);

    // single-row-of-windows map: two reads, two results
    run_map(4, 3, 0, 2, 100);

    // saturation, ReLU, shift
    set_all_w(127);
    run_map(4, 4, 0, 1, 100);
    set_all_w(-1);
    run_map(4, 4, 0, 1, 100);
    set_all_w(0);
    run_map(3, 3, 160, 1, 100);

    // writer stall at col 0 one entry short of a full window
    set_all_w(1);
    prep(5, 4, 0, 0);
    wr_en = 1;
    repeat (12) @(posedge clk);
    #1; wr_en = 0;
    kick();
    for (int i = 0; i < 6; i++) begin
      chk("stall_ren", fa.fifo_ren, 0);
      chk("stall_busy", busy_a, 1);
      @(posedge clk); #1;
    end
    wr_en = 1; @(posedge clk); #1; wr_en = 0;
    chk("resume_ren", fa.fifo_ren, 1);
    finish_map(100);

    // async reset a few cycles into RUN
    prep(5, 4, 0, 0);
    wr_en = 1;
    kick();
    repeat (3) @(posedge clk);
    #2; rst = 1'b1; #1;
    chk("arst_ov", ov_a, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_done", done_a, 0);
    chk("arst_ren", fa.fifo_ren, 0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0; wr_en = 0;
    for (int k = 0; k < 9; k++) wm[k] = 0;
    @(posedge clk); #1;
    run_map(5, 4, 37, 0, 100);     // weights cleared by reset: bias only
    set_all_w(1);
    run_map(5, 4, 0, 0, 100);

    // too-short row: straight to DONE, no reads
    prep(2, 4, 0, 0);
    wr_en = 1;
    kick();
    chk("short_done", done_a, 1);
    chk("short_busy", busy_a, 0);
    finish_map(100);

    // randomized maps; weights only reloaded on even passes
    for (int m = 0; m < 10; m++) begin
      if (m % 2 == 0) begin
        for (int k = 0; k < 9; k++) wm[k] = int'($urandom_range(0, 255)) - 128;
        put_wgts();
      end
      run_map(int'($urandom_range(3, 8)), int'($urandom_range(3, 6)),
              int'($urandom_range(0, 4000)) - 2000, 2, int'($urandom_range(30, 100)));
    end
    run_map(6, 2, 5, 2, 100);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
